// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the byte-lane enable helper used by the
// ahb_slave_mem decode logic.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'd0,
        HRESP_ERROR = 2'd1
    } hresp_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'd0,
        HSIZE_HALF = 3'd1,
        HSIZE_WORD = 3'd2
    } hsize_e;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    // Little-endian lane mask for an access of the given size at addr[1:0].
    function automatic logic [3:0] byte_en(input logic [1:0] addr, input logic [2:0] size);
        case (size)
            HSIZE_BYTE: byte_en = 4'b0001 << addr;
            HSIZE_HALF: byte_en = addr[1] ? 4'b1100 : 4'b0011;
            default:    byte_en = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/ahb_slave_mem_if.sv
// AHB-Lite bus bundle between the master model and ahb_slave_mem.
interface ahb_slave_mem_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic [1:0]  HRESP;
    logic [31:0] HRDATA;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
        input  HREADYOUT, HRESP, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
        output HREADYOUT, HRESP, HRDATA
    );
endinterface

// File: rtl/ahb_mem_array.sv
// Word-organised storage with per-byte write enables and one registered
// read port. Contents are not reset; only the read register is.
module ahb_mem_array #(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned AW          = 6
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          we_i,
    input  logic [3:0]    wbe_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    // Byte-lane write of the enabled lanes.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (wbe_i[b]) begin
                    mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Synchronous read; holds the last word read until the next read.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= 32'h0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite slave memory: address decode, response FSM, write-to-read
// forwarding. Optional build macro WAIT_STATE_EN inserts WAIT_CYCLES wait
// states ahead of every NONSEQ beat; without it all legal beats are zero-wait.
module ahb_slave_mem
    import ahb_pkg::*;
#(
    parameter logic [31:0] START_ADDR     = 32'h0,
    parameter int unsigned DEPTH_IN_BYTES = 32'h100,
    parameter int unsigned WAIT_CYCLES    = 1
) (
    input  logic            HCLK,
    input  logic            HRESET,
    ahb_slave_mem_if.slave  bus
);

    localparam int unsigned DEPTH_WORDS = DEPTH_IN_BYTES / 4;
    localparam int unsigned AW          = $clog2(DEPTH_WORDS);
`ifdef WAIT_STATE_EN
    localparam logic [2:0]  NS_WAITS    = 3'(WAIT_CYCLES);
`else
    localparam logic [2:0]  NS_WAITS    = 3'd0;
`endif

    typedef enum logic [2:0] {S_IDLE, S_DATA, S_WAIT, S_ERR1, S_ERR2} state_e;

    state_e          state_q;
    logic            hreadyout_q;
    logic            hresp_q;
    logic            wr_q;
    logic [2:0]      cnt_q;
    logic [AW-1:0]   idx_q;
    logic [3:0]      be_q;
    logic            fwd_q;
    logic [3:0]      fwd_be_q;
    logic [31:0]     fwd_data_q;

    logic [32:0]     off;
    logic            in_range;
    logic            aligned;
    logic            legal;
    logic            accept;
    logic            av;
    logic            need_wait;
    logic [AW-1:0]   idx_d;
    logic [3:0]      be_d;
    logic            mem_we;
    logic            mem_re;
    logic [31:0]     arr_rdata;
    logic [31:0]     rdata_mrg;

    // 33-bit offset so the borrow flags addresses below START_ADDR.
    assign off       = {1'b0, bus.HADDR} - {1'b0, START_ADDR};
    assign in_range  = !off[32] && (off[31:0] < DEPTH_IN_BYTES);
    assign legal     = (bus.HSIZE <= HSIZE_WORD) && aligned && in_range;
    assign accept    = (state_q == S_IDLE) || (state_q == S_DATA) || (state_q == S_ERR2);
    assign av        = accept && bus.HSEL && bus.HREADY && bus.HTRANS[1];
    assign need_wait = (bus.HTRANS == HTRANS_NONSEQ) && (NS_WAITS != 3'd0);
    assign idx_d     = off[AW+1:2];
    assign be_d      = byte_en(bus.HADDR[1:0], bus.HSIZE);
    // A write whose data phase is cut by reset never reaches the array.
    assign mem_we    = (state_q == S_DATA) && wr_q && !HRESET;
    assign mem_re    = av && legal && !bus.HWRITE;

    // Address alignment against the requested transfer size.
    always_comb begin
        aligned = 1'b1;
        case (bus.HSIZE)
            HSIZE_HALF: aligned = ~bus.HADDR[0];
            HSIZE_WORD: aligned = (bus.HADDR[1:0] == 2'b00);
            default:    aligned = 1'b1;
        endcase
    end

    // Response FSM with registered HREADYOUT/HRESP.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q     <= S_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
            wr_q        <= 1'b0;
            cnt_q       <= 3'd0;
        end else begin
            case (state_q)
                S_IDLE, S_DATA, S_ERR2: begin
                    state_q     <= S_IDLE;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= 1'b0;
                    wr_q        <= 1'b0;
                    if (av) begin
                        if (legal) begin
                            wr_q <= bus.HWRITE;
                            if (need_wait) begin
                                state_q     <= S_WAIT;
                                hreadyout_q <= 1'b0;
                                cnt_q       <= NS_WAITS;
                            end else begin
                                state_q <= S_DATA;
                            end
                        end else begin
                            state_q     <= S_ERR1;
                            hreadyout_q <= 1'b0;
                            hresp_q     <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt_q <= 3'd1) begin
                        state_q     <= S_DATA;
                        hreadyout_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                S_ERR1: begin
                    state_q     <= S_ERR2;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= 1'b1;
                end
                default: begin
                    state_q     <= S_IDLE;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= 1'b0;
                    wr_q        <= 1'b0;
                end
            endcase
        end
    end

    // Latch word index and lane mask of each accepted legal beat.
    always_ff @(posedge HCLK) begin
        if (av && legal) begin
            idx_q <= idx_d;
            be_q  <= be_d;
        end
    end

    // Note when a read hits the word being written in the same edge.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            fwd_q <= 1'b0;
        end else if (mem_re) begin
            fwd_q <= mem_we && (idx_q == idx_d);
        end
    end

    // Capture the colliding write data and lanes for the merge.
    always_ff @(posedge HCLK) begin
        if (mem_re) begin
            fwd_data_q <= bus.HWDATA;
            fwd_be_q   <= be_q;
        end
    end

    // Written lanes come from the forwarded data, the rest from the array.
    always_comb begin
        rdata_mrg = arr_rdata;
        for (int b = 0; b < 4; b++) begin
            if (fwd_q && fwd_be_q[b]) begin
                rdata_mrg[8*b +: 8] = fwd_data_q[8*b +: 8];
            end
        end
    end

    ahb_mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_mem (
        .clk_i   (HCLK),
        .rst_i   (HRESET),
        .we_i    (mem_we),
        .wbe_i   (be_q),
        .waddr_i (idx_q),
        .wdata_i (bus.HWDATA),
        .re_i    (mem_re),
        .raddr_i (idx_d),
        .rdata_o (arr_rdata)
    );

    assign bus.HREADYOUT = hreadyout_q;
    assign bus.HRESP     = hresp_q ? HRESP_ERROR : HRESP_OKAY;
    assign bus.HRDATA    = rdata_mrg;

    a_seq_in_burst: assert property (@(posedge HCLK) disable iff (HRESET)
        (bus.HSEL && bus.HTRANS == HTRANS_SEQ) |-> (bus.HBURST != HBURST_SINGLE));

    a_params: assert property (@(posedge HCLK)
        (DEPTH_IN_BYTES % 4 == 0) && (DEPTH_IN_BYTES <= 4096) && (WAIT_CYCLES <= 7));

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Directed bench for ahb_slave_mem; HREADY is looped back from HREADYOUT.
// Builds with or without WAIT_STATE_EN (WAIT_CYCLES=2 here).
module tb_ahb_slave_mem;

    localparam logic [1:0] T_IDLE = 2'd0;
    localparam logic [1:0] T_NS   = 2'd2;
    localparam logic [1:0] T_SEQ  = 2'd3;
    localparam logic [2:0] SZ_B   = 3'd0;
    localparam logic [2:0] SZ_H   = 3'd1;
    localparam logic [2:0] SZ_W   = 3'd2;
    localparam logic [2:0] B_SNGL = 3'b000;
    localparam logic [2:0] B_INC4 = 3'b011;
`ifdef WAIT_STATE_EN
    localparam int WS = 2;
`else
    localparam int WS = 0;
`endif

    logic HCLK = 1'b0;
    logic HRESET;

    ahb_slave_mem_if bus();
    assign bus.HREADY = bus.HREADYOUT;

    always #5 HCLK = ~HCLK;

    ahb_slave_mem #(
        .START_ADDR     (32'h0),
        .DEPTH_IN_BYTES (32'h100),
        .WAIT_CYCLES    (2)
    ) dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (bus)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int          waits;
    logic        first_rdy;
    logic [1:0]  first_resp;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One master cycle: drive a new address phase plus the previous beat's
    // write data, then hold everything while the slave stalls. Returns at
    // the mid-cycle sample point of the cycle in which HREADYOUT is high.
    task automatic cyc(input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                       input logic [31:0] a, input logic [2:0] bu, input logic [31:0] wd);
        @(posedge HCLK);
        #1;
        bus.HSEL   = 1'b1;
        bus.HTRANS = tr;
        bus.HWRITE = wr;
        bus.HSIZE  = sz;
        bus.HADDR  = a;
        bus.HBURST = bu;
        bus.HWDATA = wd;
        @(negedge HCLK);
        first_rdy  = bus.HREADYOUT;
        first_resp = bus.HRESP;
        waits      = 0;
        while (bus.HREADYOUT !== 1'b1 && waits < 20) begin
            @(negedge HCLK);
            waits++;
        end
        if (bus.HREADYOUT !== 1'b1) check_eq("hready_timeout", {31'h0, bus.HREADYOUT}, 32'h1);
    endtask

    task automatic idle(input logic [31:0] wd);
        cyc(T_IDLE, 1'b0, SZ_W, 32'h0, B_SNGL, wd);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.HSEL   = 1'b0;
        bus.HTRANS = T_IDLE;
        bus.HWRITE = 1'b0;
        bus.HSIZE  = SZ_W;
        bus.HADDR  = 32'h0;
        bus.HBURST = B_SNGL;
        bus.HWDATA = 32'h0;
        HRESET     = 1'b1;

        // Reset for three edges, check values while held and after release.
        repeat (3) @(posedge HCLK);
        #1;
        check_eq("rst_hready", {31'h0, bus.HREADYOUT}, 32'h1);
        check_eq("rst_hresp",  {30'h0, bus.HRESP},     32'h0);
        check_eq("rst_hrdata", bus.HRDATA,             32'h0);
        HRESET = 1'b0;
        idle(32'h0);
        idle(32'h0);
        check_eq("idle_hready", {31'h0, bus.HREADYOUT}, 32'h1);
        check_eq("idle_hresp",  {30'h0, bus.HRESP},     32'h0);
        check_eq("idle_hrdata", bus.HRDATA,             32'h0);

        // Word 0x00 = 11223344, byte A5 into lane 1, read back with overlap.
        cyc(T_NS, 1'b1, SZ_W, 32'h00, B_SNGL, 32'h0);
        cyc(T_NS, 1'b1, SZ_B, 32'h01, B_SNGL, 32'h11223344);
        check_eq("t1_ns_waits", waits, WS);
        cyc(T_NS, 1'b0, SZ_W, 32'h00, B_SNGL, 32'h0000A500);
        idle(32'h0);
        check_eq("t1_merge_rd", bus.HRDATA, 32'h1122A544);
        check_eq("t1_resp", {30'h0, bus.HRESP}, 32'h0);
        cyc(T_NS, 1'b0, SZ_W, 32'h00, B_SNGL, 32'h0);
        idle(32'h0);
        check_eq("t1_plain_rd", bus.HRDATA, 32'h1122A544);

        // Word write then read of the same word in the overlapping cycle.
        cyc(T_NS, 1'b1, SZ_W, 32'h10, B_SNGL, 32'h0);
        cyc(T_NS, 1'b0, SZ_W, 32'h10, B_SNGL, 32'hDEADBEEF);
        check_eq("t2_wr_waits", waits, WS);
        idle(32'h0);
        check_eq("t2_fwd_rd", bus.HRDATA, 32'hDEADBEEF);
        check_eq("t2_rd_waits", waits, WS);

        // INCR4 write then INCR4 read at 0x20.
        cyc(T_NS,  1'b1, SZ_W, 32'h20, B_INC4, 32'h0);
        cyc(T_SEQ, 1'b1, SZ_W, 32'h24, B_INC4, 32'h1);
        cyc(T_SEQ, 1'b1, SZ_W, 32'h28, B_INC4, 32'h2);
        check_eq("t3_seq_wr_waits", waits, 0);
        cyc(T_SEQ, 1'b1, SZ_W, 32'h2C, B_INC4, 32'h3);
        cyc(T_NS,  1'b0, SZ_W, 32'h20, B_INC4, 32'h4);
        for (int i = 1; i <= 3; i++) begin
            cyc(T_SEQ, 1'b0, SZ_W, 32'h20 + 32'(4 * i), B_INC4, 32'h0);
            check_eq($sformatf("t3_rd%0d", i), bus.HRDATA, 32'(i));
            check_eq($sformatf("t3_rd%0d_waits", i), waits, (i == 1) ? WS : 0);
        end
        idle(32'h0);
        check_eq("t3_rd4", bus.HRDATA, 32'h4);
        check_eq("t3_rd4_waits", waits, 0);
        check_eq("t3_rd4_hready", {31'h0, bus.HREADYOUT}, 32'h1);

        // Out-of-range word write: two-cycle ERROR, no memory effect.
        cyc(T_NS, 1'b1, SZ_W, 32'h100, B_SNGL, 32'h0);
        idle(32'hFFFFFFFF);
        check_eq("t4_oor_rdy1",  {31'h0, first_rdy},    32'h0);
        check_eq("t4_oor_resp1", {30'h0, first_resp},   32'h1);
        check_eq("t4_oor_rdy2",  {31'h0, bus.HREADYOUT}, 32'h1);
        check_eq("t4_oor_resp2", {30'h0, bus.HRESP},    32'h1);
        check_eq("t4_oor_waits", waits, 1);

        // Misaligned halfword write into word 0x00.
        cyc(T_NS, 1'b1, SZ_H, 32'h03, B_SNGL, 32'h0);
        idle(32'hFFFFFFFF);
        check_eq("t4_mis_rdy1",  {31'h0, first_rdy},  32'h0);
        check_eq("t4_mis_resp1", {30'h0, first_resp}, 32'h1);
        check_eq("t4_mis_resp2", {30'h0, bus.HRESP},  32'h1);
        cyc(T_NS, 1'b0, SZ_W, 32'h00, B_SNGL, 32'h0);
        idle(32'h0);
        check_eq("t4_mem_kept", bus.HRDATA, 32'h1122A544);
        check_eq("t4_resp_ok",  {30'h0, bus.HRESP}, 32'h0);

        // Reset during a write data phase drops the write.
        cyc(T_NS, 1'b1, SZ_W, 32'h30, B_SNGL, 32'h0);
        idle(32'h01020304);
        cyc(T_NS, 1'b1, SZ_W, 32'h30, B_SNGL, 32'h0);
        idle(32'hCAFEF00D);
        HRESET = 1'b1;
        idle(32'h0);
        check_eq("t5_rst_hready", {31'h0, bus.HREADYOUT}, 32'h1);
        check_eq("t5_rst_hresp",  {30'h0, bus.HRESP},     32'h0);
        check_eq("t5_rst_hrdata", bus.HRDATA,             32'h0);
        HRESET = 1'b0;
        cyc(T_NS, 1'b0, SZ_W, 32'h30, B_SNGL, 32'h0);
        idle(32'h0);
        check_eq("t5_wr_dropped", bus.HRDATA, 32'h01020304);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
